// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_port_arbiter: shares the register file write port between the         |
// | pipeline (fixed priority), the MDU and the LSU (round-robin), and keeps  |
// | a pending scoreboard for long-latency destinations.                      |
// | Optional starvation guard: define WB_ARB_STARVE_GUARD_EN.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wb_port_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_we,
  input  logic [AW-1:0] pipe_waddr,
  input  logic [DW-1:0] pipe_wdata,
  input  logic          mdu_valid,
  output logic          mdu_ready,
  input  logic [AW-1:0] mdu_waddr,
  input  logic [DW-1:0] mdu_wdata,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [AW-1:0] lsu_waddr,
  input  logic [DW-1:0] lsu_wdata,
  input  logic          issue_set,
  input  logic [AW-1:0] issue_addr,
  input  logic [AW-1:0] chk_addr1,
  input  logic [AW-1:0] chk_addr2,
  output logic          busy1,
  output logic          busy2,
  output logic          stall_req,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);

  localparam int c_nregs = 1 << AW;

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_max_check
    $error("wb_port_arbiter: STARVE_MAX must be in 1..15");
  end

  logic               r_rr_ptr;
  logic [c_nregs-1:0] r_pending;
  logic [c_nregs-1:0] w_pending_nxt;
  logic               r_rf_we;
  logic [AW-1:0]      r_rf_waddr;
  logic [DW-1:0]      r_rf_wdata;
  logic               w_mdu_gnt;
  logic               w_lsu_gnt;
  logic               w_sec_gnt;
  logic [AW-1:0]      w_sec_addr;
  logic [DW-1:0]      w_sec_data;

  // Grants are gated by rst so a request held across reset is not consumed.
  assign w_mdu_gnt  = rst & ~pipe_we & mdu_valid & (~lsu_valid | ~r_rr_ptr);
  assign w_lsu_gnt  = rst & ~pipe_we & lsu_valid & (~mdu_valid |  r_rr_ptr);
  assign w_sec_gnt  = w_mdu_gnt | w_lsu_gnt;
  assign w_sec_addr = w_mdu_gnt ? mdu_waddr : lsu_waddr;
  assign w_sec_data = w_mdu_gnt ? mdu_wdata : lsu_wdata;

  assign mdu_ready = w_mdu_gnt;
  assign lsu_ready = w_lsu_gnt;
  assign busy1     = (chk_addr1 != '0) & r_pending[chk_addr1];
  assign busy2     = (chk_addr2 != '0) & r_pending[chk_addr2];
  assign rf_we     = r_rf_we;
  assign rf_waddr  = r_rf_waddr;
  assign rf_wdata  = r_rf_wdata;

  // Clear first, then set, so an issue in the same cycle as the returning write wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_sec_gnt) w_pending_nxt[w_sec_addr] = 1'b0;
    if (issue_set) w_pending_nxt[issue_addr] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pending  <= '0;
      r_rr_ptr   <= 1'b0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (pipe_we) begin
        r_rf_we    <= (pipe_waddr != '0);
        r_rf_waddr <= pipe_waddr;
        r_rf_wdata <= pipe_wdata;
      end else if (w_sec_gnt) begin
        r_rf_we    <= (w_sec_addr != '0);
        r_rf_waddr <= w_sec_addr;
        r_rf_wdata <= w_sec_data;
      end else begin
        r_rf_we <= 1'b0;
      end
      if (w_mdu_gnt)      r_rr_ptr <= 1'b1;
      else if (w_lsu_gnt) r_rr_ptr <= 1'b0;
    end
  end

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_nxt;
  logic       r_stall;

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_sec_gnt || !(mdu_valid || lsu_valid))
      w_starve_nxt = '0;
    else if (pipe_we && r_starve_cnt < c_starve_max)
      w_starve_nxt = r_starve_cnt + 4'd1;
  end

  // Stall asserts on the edge the count saturates and drops on the edge after a grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_starve_cnt <= '0;
      r_stall      <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      if (w_sec_gnt)                         r_stall <= 1'b0;
      else if (w_starve_nxt == c_starve_max) r_stall <= 1'b1;
    end
  end

  assign stall_req = r_stall;
`else
  assign stall_req = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_port_arbiter: directed scenarios plus randomized traffic against a |
// | behavioural model of the writeback port arbiter.                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_wb_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SMAX = 4;

  logic          clk;
  logic          rst;
  logic          pipe_we;
  logic [AW-1:0] pipe_waddr;
  logic [DW-1:0] pipe_wdata;
  logic          mdu_valid, mdu_ready, lsu_valid, lsu_ready;
  logic [AW-1:0] mdu_waddr, lsu_waddr;
  logic [DW-1:0] mdu_wdata, lsu_wdata;
  logic          issue_set;
  logic [AW-1:0] issue_addr, chk_addr1, chk_addr2;
  logic          busy1, busy2, stall_req, rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  int n_chk  = 0;
  int n_pass = 0;

  wb_port_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
    .issue_set(issue_set), .issue_addr(issue_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .busy1(busy1), .busy2(busy2),
    .stall_req(stall_req), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    pipe_we = 0; pipe_waddr = '0; pipe_wdata = '0;
    mdu_valid = 0; mdu_waddr = '0; mdu_wdata = '0;
    lsu_valid = 0; lsu_waddr = '0; lsu_wdata = '0;
    issue_set = 0; issue_addr = '0; chk_addr1 = '0; chk_addr2 = '0;
  endtask

  task automatic apply_reset();
    rst = 0;
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 0;
    mdu_valid = 1; mdu_waddr = 5'd9; mdu_wdata = 32'hA5A5_0009;
    chk_addr1 = 5'd9; chk_addr2 = 5'd7;
    tick(); settle();
    n_chk++; if (mdu_ready !== 1'b0) $display("FAIL reset_mdu_ready: got %b want 0", mdu_ready); else n_pass++;
    n_chk++; if (stall_req !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_req); else n_pass++;
    n_chk++; if ({busy1, busy2} !== 2'b00) $display("FAIL reset_busy: got %b want 00", {busy1, busy2}); else n_pass++;
    tick(); settle();
    n_chk++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we: got %b want 0", rf_we); else n_pass++;
    n_chk++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0)
      $display("FAIL reset_rf_bus: got %0d/%h want 0/0", rf_waddr, rf_wdata); else n_pass++;
    n_chk++; if (mdu_ready !== 1'b0) $display("FAIL reset_mdu_ready2: got %b want 0", mdu_ready); else n_pass++;
    rst = 1;
    settle();
    n_chk++; if (mdu_ready !== 1'b1) $display("FAIL release_mdu_ready: got %b want 1", mdu_ready); else n_pass++;
    tick();
    mdu_valid = 0;
    settle();
    n_chk++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hA5A5_0009)
      $display("FAIL release_write: got we=%b %0d/%h want 1 9/a5a50009", rf_we, rf_waddr, rf_wdata); else n_pass++;
    tick(); settle();
    n_chk++; if (rf_we !== 1'b0) $display("FAIL idle_rf_we: got %b want 0", rf_we); else n_pass++;
  endtask

  task automatic test_priority();
    drive_idle();
    pipe_we = 1; pipe_waddr = 5'd3; pipe_wdata = 32'h11;
    mdu_valid = 1; mdu_waddr = 5'd4; mdu_wdata = 32'h22;
    settle();
    n_chk++; if (mdu_ready !== 1'b0) $display("FAIL prio_mdu_blocked: got %b want 0", mdu_ready); else n_pass++;
    tick();
    pipe_we = 0;
    settle();
    n_chk++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11)
      $display("FAIL prio_pipe_write: got we=%b %0d/%h want 1 3/11", rf_we, rf_waddr, rf_wdata); else n_pass++;
    n_chk++; if (mdu_ready !== 1'b1) $display("FAIL prio_mdu_ready: got %b want 1", mdu_ready); else n_pass++;
    tick();
    mdu_valid = 0;
    settle();
    n_chk++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h22)
      $display("FAIL prio_mdu_write: got we=%b %0d/%h want 1 4/22", rf_we, rf_waddr, rf_wdata); else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    drive_idle();
    apply_reset();
    mdu_valid = 1; mdu_waddr = 5'd5; mdu_wdata = 32'h55;
    lsu_valid = 1; lsu_waddr = 5'd6; lsu_wdata = 32'h66;
    settle();
    n_chk++; if ({mdu_ready, lsu_ready} !== 2'b10) $display("FAIL rr_grant0: got %b want 10", {mdu_ready, lsu_ready}); else n_pass++;
    tick(); settle();
    n_chk++; if ({mdu_ready, lsu_ready} !== 2'b01) $display("FAIL rr_grant1: got %b want 01", {mdu_ready, lsu_ready}); else n_pass++;
    n_chk++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5) $display("FAIL rr_write0: got we=%b addr %0d want 1 5", rf_we, rf_waddr); else n_pass++;
    tick(); settle();
    n_chk++; if ({mdu_ready, lsu_ready} !== 2'b10) $display("FAIL rr_grant2: got %b want 10", {mdu_ready, lsu_ready}); else n_pass++;
    n_chk++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h66)
      $display("FAIL rr_write1: got we=%b %0d/%h want 1 6/66", rf_we, rf_waddr, rf_wdata); else n_pass++;
    tick();
    mdu_valid = 0; lsu_valid = 0;
    settle();
    n_chk++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5) $display("FAIL rr_write2: got we=%b addr %0d want 1 5", rf_we, rf_waddr); else n_pass++;
    tick();
  endtask

  task automatic test_scoreboard();
    drive_idle();
    issue_set = 1; issue_addr = 5'd7; chk_addr1 = 5'd7; chk_addr2 = 5'd8;
    settle();
    n_chk++; if (busy1 !== 1'b0) $display("FAIL sb_not_yet: got %b want 0", busy1); else n_pass++;
    tick();
    issue_set = 0;
    settle();
    n_chk++; if ({busy1, busy2} !== 2'b10) $display("FAIL sb_set: got %b want 10", {busy1, busy2}); else n_pass++;
    lsu_valid = 1; lsu_waddr = 5'd7; lsu_wdata = 32'h77;
    settle();
    n_chk++; if (lsu_ready !== 1'b1 || busy1 !== 1'b1) $display("FAIL sb_grant: got ready=%b busy=%b want 1 1", lsu_ready, busy1); else n_pass++;
    tick();
    lsu_valid = 0;
    settle();
    n_chk++; if (busy1 !== 1'b0) $display("FAIL sb_clear: got %b want 0", busy1); else n_pass++;
    issue_set = 1;
    tick();
    issue_set = 0;
    lsu_valid = 1; issue_set = 1; chk_addr2 = 5'd7;
    settle();
    n_chk++; if (lsu_ready !== 1'b1) $display("FAIL sb_same_grant: got %b want 1", lsu_ready); else n_pass++;
    tick();
    lsu_valid = 0; issue_set = 0;
    settle();
    n_chk++; if ({busy1, busy2} !== 2'b11) $display("FAIL sb_set_wins: got %b want 11", {busy1, busy2}); else n_pass++;
    lsu_valid = 1;
    tick();
    lsu_valid = 0;
    settle();
    n_chk++; if ({busy1, busy2} !== 2'b00) $display("FAIL sb_final_clear: got %b want 00", {busy1, busy2}); else n_pass++;
    tick();
  endtask

  task automatic test_addr0();
    drive_idle();
    lsu_valid = 1; lsu_waddr = 5'd0; lsu_wdata = 32'hFFFF;
    issue_set = 1; issue_addr = 5'd0; chk_addr1 = 5'd0;
    settle();
    n_chk++; if (lsu_ready !== 1'b1) $display("FAIL a0_ready: got %b want 1", lsu_ready); else n_pass++;
    tick();
    lsu_valid = 0; issue_set = 0;
    settle();
    n_chk++; if (rf_we !== 1'b0) $display("FAIL a0_rf_we: got %b want 0", rf_we); else n_pass++;
    n_chk++; if (busy1 !== 1'b0) $display("FAIL a0_busy: got %b want 0", busy1); else n_pass++;
    tick();
  endtask

  task automatic test_starvation();
    drive_idle();
    apply_reset();
    pipe_we = 1; pipe_waddr = 5'd1; pipe_wdata = 32'h1111;
    mdu_valid = 1; mdu_waddr = 5'd2; mdu_wdata = 32'h2222;
    for (int k = 1; k <= 5; k++) begin
      tick(); settle();
      n_chk++; if (mdu_ready !== 1'b0) $display("FAIL starve_blocked%0d: got %b want 0", k, mdu_ready); else n_pass++;
`ifdef WB_ARB_STARVE_GUARD_EN
      n_chk++; if (stall_req !== (k >= SMAX)) $display("FAIL starve_stall%0d: got %b want %b", k, stall_req, (k >= SMAX)); else n_pass++;
`else
      n_chk++; if (stall_req !== 1'b0) $display("FAIL starve_nostall%0d: got %b want 0", k, stall_req); else n_pass++;
`endif
    end
    n_chk++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1) $display("FAIL starve_pipe_wins: got we=%b addr %0d want 1 1", rf_we, rf_waddr); else n_pass++;
    pipe_we = 0;
    settle();
    n_chk++; if (mdu_ready !== 1'b1) $display("FAIL starve_release: got %b want 1", mdu_ready); else n_pass++;
    tick();
    mdu_valid = 0;
    settle();
    n_chk++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h2222)
      $display("FAIL starve_mdu_write: got we=%b %0d/%h want 1 2/2222", rf_we, rf_waddr, rf_wdata); else n_pass++;
    n_chk++; if (stall_req !== 1'b0) $display("FAIL starve_stall_drop: got %b want 0", stall_req); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    bit            m_pend[32];
    bit            m_turn_lsu;
    int            m_cnt;
    bit            m_stall;
    bit            e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    bit            gm, gl, eb1, eb2;
    drive_idle();
    apply_reset();
    foreach (m_pend[j]) m_pend[j] = 0;
    m_turn_lsu = 0; m_cnt = 0; m_stall = 0; e_we = 0; e_addr = '0; e_data = '0;
    for (int i = 0; i < 2000; i++) begin
      rst        = ($urandom_range(63) != 0);
      pipe_we    = !m_stall && ($urandom_range(2) == 0);
      pipe_waddr = AW'($urandom_range(7));
      pipe_wdata = $urandom;
      if (!mdu_valid && $urandom_range(1) == 1) begin
        mdu_valid = 1; mdu_waddr = AW'($urandom_range(7)); mdu_wdata = $urandom;
      end
      if (!lsu_valid && $urandom_range(1) == 1) begin
        lsu_valid = 1; lsu_waddr = AW'($urandom_range(7)); lsu_wdata = $urandom;
      end
      issue_set  = ($urandom_range(3) == 0);
      issue_addr = AW'($urandom_range(7));
      chk_addr1  = AW'($urandom_range(7));
      chk_addr2  = AW'($urandom_range(7));
      settle();
      gm  = rst && !pipe_we && mdu_valid && (!lsu_valid || !m_turn_lsu);
      gl  = rst && !pipe_we && lsu_valid && (!mdu_valid || m_turn_lsu);
      eb1 = (chk_addr1 != 0) && m_pend[chk_addr1];
      eb2 = (chk_addr2 != 0) && m_pend[chk_addr2];
      n_chk++; if (mdu_ready !== gm) $display("FAIL rnd_mdu_ready@%0d: got %b want %b", i, mdu_ready, gm); else n_pass++;
      n_chk++; if (lsu_ready !== gl) $display("FAIL rnd_lsu_ready@%0d: got %b want %b", i, lsu_ready, gl); else n_pass++;
      n_chk++; if (busy1 !== eb1 || busy2 !== eb2)
        $display("FAIL rnd_busy@%0d: got %b%b want %b%b", i, busy1, busy2, eb1, eb2); else n_pass++;
      n_chk++; if (rf_we !== e_we) $display("FAIL rnd_rf_we@%0d: got %b want %b", i, rf_we, e_we); else n_pass++;
      if (e_we) begin
        n_chk++; if (rf_waddr !== e_addr || rf_wdata !== e_data)
          $display("FAIL rnd_rf_bus@%0d: got %0d/%h want %0d/%h", i, rf_waddr, rf_wdata, e_addr, e_data); else n_pass++;
      end
      n_chk++; if (stall_req !== m_stall) $display("FAIL rnd_stall@%0d: got %b want %b", i, stall_req, m_stall); else n_pass++;
      if (!rst) begin
        foreach (m_pend[j]) m_pend[j] = 0;
        m_turn_lsu = 0; m_cnt = 0; m_stall = 0; e_we = 0;
      end else begin
        if (pipe_we) begin
          e_we = (pipe_waddr != 0); e_addr = pipe_waddr; e_data = pipe_wdata;
        end else if (gm) begin
          e_we = (mdu_waddr != 0); e_addr = mdu_waddr; e_data = mdu_wdata;
        end else if (gl) begin
          e_we = (lsu_waddr != 0); e_addr = lsu_waddr; e_data = lsu_wdata;
        end else begin
          e_we = 0;
        end
        if (gm) m_pend[mdu_waddr] = 0;
        if (gl) m_pend[lsu_waddr] = 0;
        if (issue_set && issue_addr != 0) m_pend[issue_addr] = 1;
        if (gm) m_turn_lsu = 1;
        else if (gl) m_turn_lsu = 0;
`ifdef WB_ARB_STARVE_GUARD_EN
        if (gm || gl || !(mdu_valid || lsu_valid)) m_cnt = 0;
        else if (pipe_we && m_cnt < SMAX) m_cnt = m_cnt + 1;
        if (gm || gl) m_stall = 0;
        else if (m_cnt >= SMAX) m_stall = 1;
`endif
      end
      tick();
      if (gm) mdu_valid = 0;
      if (gl) lsu_valid = 0;
    end
  endtask

  initial begin
    rst = 0;
    drive_idle();
    test_reset();
    test_priority();
    test_round_robin();
    test_scoreboard();
    test_addr0();
    test_starvation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port between three writeback sources: the in-order pipeline, the multiply/divide unit (MDU) and the load-miss return path (LSU). Pipeline writes always win; the MDU and LSU compete round-robin through valid/ready handshakes. A 32-entry pending scoreboard lets decode stall on registers awaiting a long-latency result. The block sits between the writeback stage and the register file write port (`we`/`waddr`/`wdata`).

## Interface
- `DW`, 32: data width.
- `AW`, 5: register address width; the scoreboard has 2^AW entries.
- `STARVE_MAX`, 4: consecutive lost cycles before the starvation guard fires (range 1..15).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `pipe_we`  in  1  pipeline writeback request; never back-pressured.
- `pipe_waddr`  in  AW  pipeline destination register.
- `pipe_wdata`  in  DW  pipeline write data.
- `mdu_valid`, `lsu_valid`  in  1  secondary write requests.
- `mdu_ready`, `lsu_ready`  out  1  grants; combinational.
- `mdu_waddr`, `lsu_waddr`  in  AW  secondary destination registers.
- `mdu_wdata`, `lsu_wdata`  in  DW  secondary write data.
- `issue_set`  in  1  decode issued a long-latency op; mark `issue_addr` pending.
- `issue_addr`  in  AW  register to mark pending.
- `chk_addr1`, `chk_addr2`  in  AW  decode source operands.
- `busy1`, `busy2`  out  1  the corresponding source register is pending; combinational.
- `stall_req`  out  1  asks the pipeline to hold off writeback; registered.
- `rf_we`  out  1  register file write enable; registered.
- `rf_waddr`  out  AW  register file write address; registered.
- `rf_wdata`  out  DW  register file write data; registered.

## Operation
- **Handshakes.** A transfer occurs when `x_valid && x_ready`. Once `x_valid` is raised, it and its addr/data must stay stable until `x_ready`.
- **Priority.**
  - If `pipe_we` is 1, the pipeline is selected, and `mdu_ready` and `lsu_ready` are both 0.
  - Otherwise, if exactly one secondary is valid, it is granted.
  - If both are valid, the one selected by `rr_ptr` is granted (0 = MDU, 1 = LSU).
  - After any secondary grant, `rr_ptr` points to the other source.
- **Writes to address 0.** The handshake completes normally. `rf_we` stays 0 and the scoreboard is not touched.
- **Scoreboard.** `pending[2^AW]` register.
  - `issue_set` with a nonzero `issue_addr` sets the bit.
  - A granted MDU/LSU write clears the bit at its address.
  - Set and clear of the same address in the same cycle: set wins.
  - Pipeline writes never clear bits.
  - `busyN = pending[chk_addrN]`; address 0 always returns 0.
- **Reset** (`rst == 0` at an edge):
  - `pending`, `rr_ptr` and the starvation counter are cleared.
  - `rf_we`, `rf_waddr`, `rf_wdata` and `stall_req` are reset to 0.
  - `mdu_ready` and `lsu_ready` are forced to 0 while `rst == 0`.
  - An in-flight secondary request is not consumed; it must be re-presented after reset.

## Timing
- Grant in cycle N → `rf_we`/`rf_waddr`/`rf_wdata` are valid in cycle N+1, for exactly one cycle.
- If nothing is selected in cycle N, `rf_we` is 0 in cycle N+1.
- A pending bit cleared by a grant at edge N is 0 from cycle N+1. The register file's same-cycle write bypass covers the in-flight write during that cycle.
- A pending bit set by `issue_set` in cycle N reads as busy from cycle N+1.
- Throughput: one write per cycle. No bubbles are inserted between back-to-back secondary grants.

## Configuration
- **`WB_ARB_STARVE_GUARD_EN` defined:**
  - A saturating counter increments each cycle in which `pipe_we` is 1 and (`mdu_valid` or `lsu_valid`) is 1.
  - The counter clears on any secondary grant, or when neither secondary is valid.
  - When the counter reaches `STARVE_MAX`, `stall_req` is registered to 1. It holds until the edge following a secondary grant.
  - The pipeline must keep `pipe_we` at 0 while `stall_req` is 1. If it violates this, the pipeline still wins; a pipeline write is never dropped.
- **Not defined:** `stall_req` is tied to 0, the counter is absent, and secondaries may starve indefinitely.

## Test plan
- **Reset:** hold `rst = 0` for 2 cycles with `mdu_valid = 1` → `mdu_ready = 0`, and `rf_we`, `busy1`, `busy2`, `stall_req` all 0. Release → MDU granted next cycle.
- **Priority:** `pipe_we = 1` to r3 with 0x11, `mdu_valid = 1` to r4 with 0x22 → cycle N+1 shows `rf_waddr = 3`, `rf_wdata = 0x11`; `mdu_ready` rises when `pipe_we` drops, and r4 = 0x22 is written one cycle later.
- **Round-robin:** MDU (r5) and LSU (r6) valid continuously, `pipe_we = 0` → grants alternate MDU, LSU, MDU. Writes to r5 and r6 appear on consecutive cycles.
- **Scoreboard:**
  - `issue_set` r7 → `busy1 = 1` for `chk_addr1 = 7` from the next cycle.
  - LSU write to r7 granted → `busy1 = 0` the cycle after.
  - `issue_set` r7 in the same cycle as the grant → `busy1` stays 1.
- **Address 0:** LSU write to r0 with 0xFFFF → handshake completes, `rf_we = 0`, `busy` for r0 stays 0.
- **Starvation** (with `WB_ARB_STARVE_GUARD_EN`, `STARVE_MAX = 4`): `pipe_we = 1` every cycle with `mdu_valid = 1` → `stall_req = 1` after 4 lost cycles. Dropping `pipe_we` → MDU granted, and `stall_req = 0` on the following cycle.
